// File: rtl/rheed_sched_pkg.sv
// Shared types and helpers for the RHEED frame scheduler.
package rheed_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int LAT_W = 32;

  // Clamp a requested crop origin to the last legal origin. Both operands are
  // widened to 32-bit unsigned so the compare never wraps.
  function automatic int unsigned clamp_origin(input int unsigned req,
                                               input int unsigned max_origin);
    return (req > max_origin) ? max_origin : req;
  endfunction

endpackage

// File: rtl/rheed_frame_scheduler_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  // Next value: clear has priority, increment stops at the ceiling.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/rheed_frame_scheduler.sv
// Frame-level sequencer for the RHEED inference pipeline: one ap_start per
// accepted start-of-frame, stable crop window per frame, completion by result
// beat count, drop counting, sticky timeout flag.
// Optional latency statistics are built when RHEED_SCHED_PERF_EN is defined;
// otherwise last_latency/max_latency read as zero.
//
// Handshakes: ap_start is raised in START and held until a cycle in which
// pipe_ap_ready is 1 (that cycle is the acceptance); a result beat is any
// cycle with res_tvalid && res_tready while in RUN. Both are sampled on the
// rising clock edge.
module rheed_frame_scheduler
  import rheed_sched_pkg::*;
#(
  parameter int IN_ROWS        = 20,
  parameter int IN_COLS        = 20,
  parameter int OUT_ROWS       = 20,
  parameter int OUT_COLS       = 20,
  parameter int NUM_RESULTS    = 1,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       sof,
  input  logic [$clog2(IN_COLS)-1:0] cfg_crop_x0,
  input  logic [$clog2(IN_ROWS)-1:0] cfg_crop_y0,
  input  logic                       cfg_update,
  input  logic                       pipe_ap_ready,
  output logic                       ap_start,
  output logic [$clog2(IN_COLS)-1:0] crop_x0,
  output logic [$clog2(IN_ROWS)-1:0] crop_y0,
  input  logic                       res_tvalid,
  input  logic                       res_tready,
  output logic                       busy,
  output logic [CNT_W-1:0]           frames_done,
  output logic [CNT_W-1:0]           frames_dropped,
  output logic                       timeout_err,
  input  logic                       err_clr,
  output logic [LAT_W-1:0]           last_latency,
  output logic [LAT_W-1:0]           max_latency
);

  localparam int XW     = $clog2(IN_COLS);
  localparam int YW     = $clog2(IN_ROWS);
  localparam int BEAT_W = $clog2(NUM_RESULTS + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned X_MAX = IN_COLS - OUT_COLS;
  localparam int unsigned Y_MAX = IN_ROWS - OUT_ROWS;

  state_t            state_q, state_d;
  logic              ap_start_q, ap_start_d;
  logic              busy_q, busy_d;
  logic [XW-1:0]     crop_x_q, crop_x_d, pend_x_q, pend_x_d;
  logic [YW-1:0]     crop_y_q, crop_y_d, pend_y_q, pend_y_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;

  logic [XW-1:0] cfg_x_clamped;
  logic [YW-1:0] cfg_y_clamped;
  logic          beat, last_beat, tmo_hit, accept, tmo_fire;
  logic          start_now, done_inc, drop_inc;

  assign cfg_x_clamped = XW'(clamp_origin(32'(cfg_crop_x0), X_MAX));
  assign cfg_y_clamped = YW'(clamp_origin(32'(cfg_crop_y0), Y_MAX));

  assign beat      = res_tvalid && res_tready;
  assign last_beat = (state_q == RUN) && beat && (beat_q == BEAT_W'(NUM_RESULTS - 1));
  assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign accept    = (state_q == START) && pipe_ap_ready && !tmo_hit;
  // Completion on the same cycle as the deadline counts as completion.
  assign tmo_fire  = tmo_hit && ((state_q == START) || ((state_q == RUN) && !last_beat));

  // Next-state, start strobe, crop/shadow updates and counter events.
  always_comb begin
    state_d    = state_q;
    ap_start_d = ap_start_q;
    crop_x_d   = crop_x_q;
    crop_y_d   = crop_y_q;
    pend_x_d   = pend_x_q;
    pend_y_d   = pend_y_q;
    beat_d     = beat_q;
    tmo_d      = tmo_q;
    start_now  = 1'b0;
    done_inc   = 1'b0;
    drop_inc   = 1'b0;

    case (state_q)
      IDLE: begin
        start_now = sof && enable;
      end
      START: begin
        drop_inc = sof;
        if (tmo_hit) begin
          state_d    = IDLE;
          ap_start_d = 1'b0;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (accept) begin
            state_d    = RUN;
            ap_start_d = 1'b0;
          end
        end
      end
      RUN: begin
        if (last_beat) begin
          // A sof landing on the completion cycle restarts instead of dropping.
          done_inc = 1'b1;
          if (sof && enable) begin
            start_now = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          drop_inc = sof;
          if (tmo_hit) begin
            state_d = IDLE;
          end else begin
            tmo_d = tmo_q + 1'b1;
            if (beat) begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d    = IDLE;
        ap_start_d = 1'b0;
      end
    endcase

    if (start_now) begin
      state_d    = START;
      ap_start_d = 1'b1;
      tmo_d      = '0;
      beat_d     = '0;
      // A same-cycle cfg_update bypasses the shadow.
      crop_x_d   = cfg_update ? cfg_x_clamped : pend_x_q;
      crop_y_d   = cfg_update ? cfg_y_clamped : pend_y_q;
    end

    if (cfg_update) begin
      pend_x_d = cfg_x_clamped;
      pend_y_d = cfg_y_clamped;
    end
  end

  // Sticky timeout flag; a new timeout beats a same-cycle clear.
  always_comb begin
    err_d  = err_q;
    busy_d = (state_d != IDLE);
    if (tmo_fire) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ap_start_q <= 1'b0;
      busy_q     <= 1'b0;
      crop_x_q   <= '0;
      crop_y_q   <= '0;
      pend_x_q   <= '0;
      pend_y_q   <= '0;
      beat_q     <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ap_start_q <= ap_start_d;
      busy_q     <= busy_d;
      crop_x_q   <= crop_x_d;
      crop_y_q   <= crop_y_d;
      pend_x_q   <= pend_x_d;
      pend_y_q   <= pend_y_d;
      beat_q     <= beat_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_done_cnt (
    .clk (clk),
    .rst (reset),
    .clr (1'b0),
    .inc (done_inc),
    .q   (frames_done)
  );

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk (clk),
    .rst (reset),
    .clr (1'b0),
    .inc (drop_inc),
    .q   (frames_dropped)
  );

`ifdef RHEED_SCHED_PERF_EN
  logic [LAT_W-1:0] lat_cnt, lat_now;
  logic [LAT_W-1:0] last_lat_q, last_lat_d, max_lat_q, max_lat_d;

  // Cleared on acceptance, counts RUN cycles; latency = count + 1 at last beat.
  sat_counter #(.W(LAT_W)) u_lat_cnt (
    .clk (clk),
    .rst (reset),
    .clr (accept),
    .inc (state_q == RUN),
    .q   (lat_cnt)
  );

  assign lat_now = (lat_cnt == {LAT_W{1'b1}}) ? lat_cnt : lat_cnt + 1'b1;

  // Latch latency statistics on completed frames only.
  always_comb begin
    last_lat_d = last_lat_q;
    max_lat_d  = max_lat_q;
    if (done_inc) begin
      last_lat_d = lat_now;
      if (lat_now > max_lat_q) begin
        max_lat_d = lat_now;
      end
    end
  end

  // Latency statistic registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_lat_q <= '0;
      max_lat_q  <= '0;
    end else begin
      last_lat_q <= last_lat_d;
      max_lat_q  <= max_lat_d;
    end
  end

  assign last_latency = last_lat_q;
  assign max_latency  = max_lat_q;
`else
  assign last_latency = '0;
  assign max_latency  = '0;
`endif

  assign ap_start    = ap_start_q;
  assign busy        = busy_q;
  assign crop_x0     = crop_x_q;
  assign crop_y0     = crop_y_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_rheed_frame_scheduler.sv
// Self-checking bench for rheed_frame_scheduler: directed scenarios plus a
// randomized run checked against a frame-level reference model.
module tb_rheed_frame_scheduler;

  localparam int IN_ROWS = 20, IN_COLS = 20, OUT_ROWS = 8, OUT_COLS = 8;
  localparam int NUM_RESULTS = 1, TIMEOUT_CYCLES = 100, CNT_W = 4;
  localparam int XW = $clog2(IN_COLS), YW = $clog2(IN_ROWS);
  localparam int X_MAX = IN_COLS - OUT_COLS, Y_MAX = IN_ROWS - OUT_ROWS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          enable = 0, sof = 0, cfg_update = 0, pipe_ap_ready = 0;
  logic [XW-1:0] cfg_crop_x0 = '0;
  logic [YW-1:0] cfg_crop_y0 = '0;
  logic          res_tvalid = 0, res_tready = 0, err_clr = 0;
  logic          ap_start, busy, timeout_err;
  logic [XW-1:0] crop_x0;
  logic [YW-1:0] crop_y0;
  logic [CNT_W-1:0] frames_done, frames_dropped;
  logic [31:0]   last_latency, max_latency;

  rheed_frame_scheduler #(
    .IN_ROWS(IN_ROWS), .IN_COLS(IN_COLS), .OUT_ROWS(OUT_ROWS), .OUT_COLS(OUT_COLS),
    .NUM_RESULTS(NUM_RESULTS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sof(sof),
    .cfg_crop_x0(cfg_crop_x0), .cfg_crop_y0(cfg_crop_y0), .cfg_update(cfg_update),
    .pipe_ap_ready(pipe_ap_ready), .ap_start(ap_start),
    .crop_x0(crop_x0), .crop_y0(crop_y0),
    .res_tvalid(res_tvalid), .res_tready(res_tready), .busy(busy),
    .frames_done(frames_done), .frames_dropped(frames_dropped),
    .timeout_err(timeout_err), .err_clr(err_clr),
    .last_latency(last_latency), .max_latency(max_latency)
  );

  int total = 0;
  int bad = 0;

  // ---------------- reference model (frame level) ----------------
  longint        cyc = 0;
  logic          m_busy, m_acc, m_err;
  int            m_beats;
  longint        m_start, m_acc_cyc;
  logic [XW-1:0] m_cx, m_px;
  logic [YW-1:0] m_cy, m_py;
  logic [CNT_W-1:0] m_done, m_drop;
  logic [31:0]   m_last, m_max;

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_err = 0; m_beats = 0; m_start = 0; m_acc_cyc = 0;
    m_cx = 0; m_cy = 0; m_px = 0; m_py = 0; m_done = 0; m_drop = 0;
    m_last = 0; m_max = 0;
  endtask

  // Advance one clock edge and apply the frame rules to the sampled inputs.
  task automatic tick();
    logic b, done_now, tmo_now, start_now;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    longint lat;
    @(posedge clk);
    cyc++;
    b  = res_tvalid && res_tready;
    cx = (int'(cfg_crop_x0) > X_MAX) ? XW'(X_MAX) : cfg_crop_x0;
    cy = (int'(cfg_crop_y0) > Y_MAX) ? YW'(Y_MAX) : cfg_crop_y0;
    done_now  = m_busy && m_acc && b && (m_beats + 1 == NUM_RESULTS);
    tmo_now   = m_busy && !done_now && (cyc - m_start == TIMEOUT_CYCLES);
    start_now = 0;
    if (!m_busy) begin
      start_now = sof && enable;
    end else if (done_now) begin
      if (m_done != {CNT_W{1'b1}}) m_done++;
`ifdef RHEED_SCHED_PERF_EN
      lat = cyc - m_acc_cyc;
      if (lat > 64'hFFFF_FFFF) lat = 64'hFFFF_FFFF;
      m_last = 32'(lat);
      if (m_last > m_max) m_max = m_last;
`else
      lat = 0;
`endif
      if (sof && enable) start_now = 1;
      else m_busy = 0;
    end else if (tmo_now) begin
      m_busy = 0;
      if (sof && m_drop != {CNT_W{1'b1}}) m_drop++;
    end else begin
      if (sof && m_drop != {CNT_W{1'b1}}) m_drop++;
      if (m_acc && b) m_beats++;
      if (!m_acc && pipe_ap_ready) begin
        m_acc = 1; m_acc_cyc = cyc;
      end
    end
    if (tmo_now) m_err = 1;
    else if (err_clr) m_err = 0;
    if (start_now) begin
      m_busy = 1; m_acc = 0; m_beats = 0; m_start = cyc;
      m_cx = cfg_update ? cx : m_px;
      m_cy = cfg_update ? cy : m_py;
    end
    if (cfg_update) begin
      m_px = cx; m_py = cy;
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1; enable = 0; sof = 0; cfg_update = 0; pipe_ap_ready = 0;
    cfg_crop_x0 = 0; cfg_crop_y0 = 0; res_tvalid = 0; res_tready = 0; err_clr = 0;
    @(negedge clk);
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic start_frame();
    sof = 1; tick(); sof = 0;
  endtask

  task automatic send_beat();
    res_tvalid = 1; res_tready = 1; tick(); res_tvalid = 0; res_tready = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    total++; if (ap_start !== 1'b0) begin bad++; $display("FAIL reset_ap_start: got %0b want 0", ap_start); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (crop_x0 !== '0 || crop_y0 !== '0) begin bad++; $display("FAIL reset_crop: got %0d,%0d want 0,0", crop_x0, crop_y0); end
    total++; if (frames_done !== '0 || frames_dropped !== '0) begin bad++; $display("FAIL reset_counters: got %0d,%0d want 0,0", frames_done, frames_dropped); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", timeout_err); end
    total++; if (last_latency !== 32'd0 || max_latency !== 32'd0) begin bad++; $display("FAIL reset_latency: got %0d,%0d want 0,0", last_latency, max_latency); end
  endtask

  task automatic test_basic_frame();
    do_reset();
    enable = 1; pipe_ap_ready = 1;
    cfg_crop_x0 = 3; cfg_crop_y0 = 4; cfg_update = 1; tick(); cfg_update = 0;
    start_frame();
    total++; if (ap_start !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL basic_start: ap_start=%0b busy=%0b want 1,1", ap_start, busy); end
    total++; if (crop_x0 !== 3 || crop_y0 !== 4) begin bad++; $display("FAIL basic_crop_start: got %0d,%0d want 3,4", crop_x0, crop_y0); end
    tick();
    total++; if (ap_start !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL basic_accept: ap_start=%0b busy=%0b want 0,1", ap_start, busy); end
    total++; if (crop_x0 !== 3 || crop_y0 !== 4) begin bad++; $display("FAIL basic_crop_run: got %0d,%0d want 3,4", crop_x0, crop_y0); end
    send_beat();
    total++; if (busy !== 1'b0 || frames_done !== 1) begin bad++; $display("FAIL basic_done: busy=%0b done=%0d want 0,1", busy, frames_done); end
    total++; if (last_latency !== m_last || max_latency !== m_max) begin bad++; $display("FAIL basic_latency: got %0d,%0d want %0d,%0d", last_latency, max_latency, m_last, m_max); end
  endtask

  task automatic test_backpressure();
    int high;
    do_reset();
    enable = 1; pipe_ap_ready = 0;
    start_frame();
    high = (ap_start === 1'b1) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ap_start === 1'b1) high++;
    end
    total++; if (high !== 6) begin bad++; $display("FAIL bp_held: got %0d cycles want 6", high); end
    pipe_ap_ready = 1; tick();
    total++; if (ap_start !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL bp_run: ap_start=%0b busy=%0b want 0,1", ap_start, busy); end
    send_beat();
    total++; if (frames_done !== 1 || busy !== 1'b0) begin bad++; $display("FAIL bp_done: done=%0d busy=%0b want 1,0", frames_done, busy); end
  endtask

  task automatic test_drop_simultaneous();
    do_reset();
    enable = 1; pipe_ap_ready = 1;
    start_frame(); tick();
    sof = 1; tick(); sof = 0;
    total++; if (frames_dropped !== 1 || busy !== 1'b1 || ap_start !== 1'b0) begin bad++; $display("FAIL drop_run: drop=%0d busy=%0b ap=%0b want 1,1,0", frames_dropped, busy, ap_start); end
    sof = 1; res_tvalid = 1; res_tready = 1; tick(); sof = 0; res_tvalid = 0; res_tready = 0;
    total++; if (frames_dropped !== 1 || frames_done !== 1) begin bad++; $display("FAIL drop_simul_counts: drop=%0d done=%0d want 1,1", frames_dropped, frames_done); end
    total++; if (ap_start !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL drop_simul_restart: ap=%0b busy=%0b want 1,1", ap_start, busy); end
    tick(); send_beat();
    total++; if (frames_done !== 2 || busy !== 1'b0) begin bad++; $display("FAIL drop_second_done: done=%0d busy=%0b want 2,0", frames_done, busy); end
  endtask

  task automatic test_enable_midframe();
    do_reset();
    enable = 1; pipe_ap_ready = 1;
    start_frame(); tick();
    enable = 0; tick();
    send_beat();
    total++; if (frames_done !== 1 || busy !== 1'b0) begin bad++; $display("FAIL en_complete: done=%0d busy=%0b want 1,0", frames_done, busy); end
    sof = 1; tick(); sof = 0;
    total++; if (busy !== 1'b0 || ap_start !== 1'b0 || frames_dropped !== 0) begin bad++; $display("FAIL en_no_start: busy=%0b ap=%0b drop=%0d want 0,0,0", busy, ap_start, frames_dropped); end
  endtask

  task automatic test_crop_shadow();
    do_reset();
    enable = 1; pipe_ap_ready = 1;
    cfg_crop_x0 = 2; cfg_crop_y0 = 2; cfg_update = 1; tick(); cfg_update = 0;
    start_frame(); tick();
    cfg_crop_x0 = 15; cfg_crop_y0 = 3; cfg_update = 1; tick(); cfg_update = 0;
    total++; if (crop_x0 !== 2 || crop_y0 !== 2) begin bad++; $display("FAIL shadow_hold: got %0d,%0d want 2,2", crop_x0, crop_y0); end
    send_beat();
    start_frame();
    total++; if (crop_x0 !== 12 || crop_y0 !== 3) begin bad++; $display("FAIL shadow_load: got %0d,%0d want 12,3", crop_x0, crop_y0); end
    tick(); send_beat();
    cfg_crop_x0 = 19; cfg_crop_y0 = 31; cfg_update = 1; sof = 1; tick(); cfg_update = 0; sof = 0;
    total++; if (crop_x0 !== 12 || crop_y0 !== 12) begin bad++; $display("FAIL crop_bypass: got %0d,%0d want 12,12", crop_x0, crop_y0); end
    tick(); send_beat();
  endtask

  task automatic test_timeout();
    do_reset();
    enable = 1; pipe_ap_ready = 1;
    start_frame();
    for (int k = 1; k <= TIMEOUT_CYCLES; k++) begin
      tick();
      if (k == TIMEOUT_CYCLES - 1) begin
        total++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL tmo_early: err=%0b busy=%0b want 0,1", timeout_err, busy); end
      end
    end
    total++; if (timeout_err !== 1'b1 || busy !== 1'b0 || frames_done !== 0) begin bad++; $display("FAIL tmo_fire: err=%0b busy=%0b done=%0d want 1,0,0", timeout_err, busy, frames_done); end
    err_clr = 1; tick(); err_clr = 0;
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_clear: got %0b want 0", timeout_err); end
    // Timeout while still waiting for acceptance, with a clear on the same edge.
    pipe_ap_ready = 0;
    start_frame();
    for (int k = 1; k <= TIMEOUT_CYCLES; k++) begin
      if (k == TIMEOUT_CYCLES) err_clr = 1;
      tick();
    end
    err_clr = 0;
    total++; if (timeout_err !== 1'b1 || ap_start !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL tmo_set_wins: err=%0b ap=%0b busy=%0b want 1,0,0", timeout_err, ap_start, busy); end
    tick();
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky: got %0b want 1", timeout_err); end
  endtask

  task automatic test_reset_and_saturation();
    do_reset();
    enable = 1; pipe_ap_ready = 1;
    cfg_crop_x0 = 5; cfg_crop_y0 = 6; cfg_update = 1; tick(); cfg_update = 0;
    start_frame(); tick(); send_beat();
    start_frame(); tick();
    sof = 1;
    for (int i = 0; i < 20; i++) tick();
    sof = 0;
    total++; if (frames_dropped !== 15 || busy !== 1'b1) begin bad++; $display("FAIL drop_saturate: drop=%0d busy=%0b want 15,1", frames_dropped, busy); end
    reset = 1; #2;
    model_reset();
    total++; if (ap_start !== 0 || busy !== 0 || timeout_err !== 0) begin bad++; $display("FAIL midrun_reset_ctrl: ap=%0b busy=%0b err=%0b want 0,0,0", ap_start, busy, timeout_err); end
    total++; if (crop_x0 !== 0 || crop_y0 !== 0 || frames_done !== 0 || frames_dropped !== 0) begin bad++; $display("FAIL midrun_reset_regs: crop=%0d,%0d done=%0d drop=%0d want zeros", crop_x0, crop_y0, frames_done, frames_dropped); end
    reset = 0;
  endtask

  task automatic test_random();
    bit starve;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if (n % 400 == 0) starve = ($urandom_range(0, 2) == 0);
      enable        = ($urandom_range(0, 9) != 0);
      sof           = ($urandom_range(0, 7) == 0);
      cfg_update    = ($urandom_range(0, 9) == 0);
      cfg_crop_x0   = XW'($urandom_range(0, 31));
      cfg_crop_y0   = YW'($urandom_range(0, 31));
      pipe_ap_ready = ($urandom_range(0, 2) != 0);
      res_tvalid    = starve ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 3) == 0);
      res_tready    = ($urandom_range(0, 1) == 0);
      err_clr       = ($urandom_range(0, 49) == 0);
      tick();
      total++; if (ap_start !== (m_busy && !m_acc)) begin bad++; $display("FAIL rnd_ap_start cyc=%0d: got %0b want %0b", cyc, ap_start, m_busy && !m_acc); end
      total++; if (busy !== m_busy) begin bad++; $display("FAIL rnd_busy cyc=%0d: got %0b want %0b", cyc, busy, m_busy); end
      total++; if (crop_x0 !== m_cx || crop_y0 !== m_cy) begin bad++; $display("FAIL rnd_crop cyc=%0d: got %0d,%0d want %0d,%0d", cyc, crop_x0, crop_y0, m_cx, m_cy); end
      total++; if (frames_done !== m_done) begin bad++; $display("FAIL rnd_done cyc=%0d: got %0d want %0d", cyc, frames_done, m_done); end
      total++; if (frames_dropped !== m_drop) begin bad++; $display("FAIL rnd_drop cyc=%0d: got %0d want %0d", cyc, frames_dropped, m_drop); end
      total++; if (timeout_err !== m_err) begin bad++; $display("FAIL rnd_err cyc=%0d: got %0b want %0b", cyc, timeout_err, m_err); end
      total++; if (last_latency !== m_last || max_latency !== m_max) begin bad++; $display("FAIL rnd_latency cyc=%0d: got %0d,%0d want %0d,%0d", cyc, last_latency, max_latency, m_last, m_max); end
      if ($urandom_range(0, 499) == 0) begin
        reset = 1; #1; model_reset(); #1; reset = 0;
      end
    end
    sof = 0; cfg_update = 0; res_tvalid = 0; res_tready = 0; err_clr = 0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_drop_simultaneous();
    test_enable_midframe();
    test_crop_shadow();
    test_timeout();
    test_reset_and_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
